// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner: row strobe patterns (the same
// one-hot-low patterns the seven-segment digit scanner uses), the debounce
// state encoding and the key code width.
package keypad_scan_pkg;

  localparam int KEY_W = 4;

  // Row strobe pattern indexed by row_idx; exactly one line low.
  localparam logic [3:0] ROW_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } deb_state_t;

  // Index of the lowest-numbered low bit of an active-low column word.
  // Callers only use the result when at least one bit is low.
  function automatic logic [1:0] first_low(input logic [3:0] c);
    if (!c[0])      first_low = 2'd0;
    else if (!c[1]) first_low = 2'd1;
    else if (!c[2]) first_low = 2'd2;
    else            first_low = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM. It is evaluated only on frame_valid (one cycle
// per scan frame) and turns the per-frame hit/code into a held key level
// plus single-cycle press/release pulses. A different key while one is
// held is treated as a release; there is no rollover.
module keypad_debounce
  import keypad_scan_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  input  logic             frame_hit,
  input  logic [KEY_W-1:0] frame_code,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_pressed,
  output logic             key_released,
  output deb_state_t       state
);

  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] DF = SW'(DEBOUNCE_FRAMES);
  localparam logic [SW-1:0] ONE = SW'(1);

  deb_state_t       state_n;
  logic [KEY_W-1:0] candidate, candidate_n;
  logic [SW-1:0]    stable, stable_n, stable_inc;
  logic [KEY_W-1:0] key_code_n;
  logic             key_valid_n, key_pressed_n, key_released_n;

  // Frame counter saturates so it never wraps past the acceptance threshold.
  assign stable_inc = (stable == DF) ? stable : stable + ONE;

  // State and output registers; pulses are registered so they appear the
  // cycle after the frame-end sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      candidate    <= '0;
      stable       <= '0;
      key_code     <= '0;
      key_valid    <= 1'b0;
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
    end else begin
      state        <= state_n;
      candidate    <= candidate_n;
      stable       <= stable_n;
      key_code     <= key_code_n;
      key_valid    <= key_valid_n;
      key_pressed  <= key_pressed_n;
      key_released <= key_released_n;
    end
  end

  // Next-state and next-output logic, only acting at frame end.
  always_comb begin
    state_n        = state;
    candidate_n    = candidate;
    stable_n       = stable;
    key_code_n     = key_code;
    key_valid_n    = key_valid;
    key_pressed_n  = 1'b0;
    key_released_n = 1'b0;
    if (frame_valid) begin
      case (state)
        IDLE: begin
          if (frame_hit) begin
            state_n     = DEB_PRESS;
            candidate_n = frame_code;
            stable_n    = ONE;
          end
        end
        DEB_PRESS: begin
          if (frame_hit && (frame_code == candidate)) begin
            stable_n = stable_inc;
            if (stable_inc == DF) begin
              state_n       = HELD;
              key_code_n    = candidate;
              key_valid_n   = 1'b1;
              key_pressed_n = 1'b1;
            end
          end else if (frame_hit) begin
            candidate_n = frame_code;
            stable_n    = ONE;
          end else begin
            state_n  = IDLE;
            stable_n = '0;
          end
        end
        HELD: begin
          if (!(frame_hit && (frame_code == key_code))) begin
            state_n  = DEB_REL;
            stable_n = ONE;
          end
        end
        DEB_REL: begin
          if (frame_hit && (frame_code == key_code)) begin
            state_n = HELD;
          end else begin
            stable_n = stable_inc;
            if (stable_inc == DF) begin
              state_n        = IDLE;
              key_valid_n    = 1'b0;
              key_released_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner. Strobes one active-low row every SCAN_DIV
// cycles, synchronises the active-low column returns, keeps the first hit
// of each 4-row frame and hands one frame result per frame to the
// debounce FSM. Columns are sampled on the last dwell cycle of each row so
// the synchroniser has settled after the row change.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       row,
  input  logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_pressed,
  output logic             key_released,
  output deb_state_t       dbg_state
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0]    dwell;
  logic [1:0]       row_idx;
  logic [3:0]       col_s1, col_s2;
  logic             acc_hit;
  logic [KEY_W-1:0] acc_code;
  logic             sample, cur_hit;
  logic [KEY_W-1:0] cur_code;
  logic             frame_valid, frame_hit;
  logic [KEY_W-1:0] frame_code;

  assign sample      = (dwell == DWELL_LAST);
  assign cur_hit     = ~&col_s2;
  assign cur_code    = {row_idx, first_low(col_s2)};
  assign frame_valid = sample && (row_idx == 2'd3);
  // The earliest hit in the frame wins, including one from the row-3 sample.
  assign frame_hit   = acc_hit || cur_hit;
  assign frame_code  = acc_hit ? acc_code : cur_code;
  assign row         = ROW_PAT[row_idx];

  // Row dwell counter and row index; the index advances after each sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell   <= '0;
      row_idx <= 2'd0;
    end else if (sample) begin
      dwell   <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous column returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  // Frame accumulator: latch the first hit, clear when the frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (frame_valid) begin
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (sample && cur_hit && !acc_hit) begin
      acc_hit  <= 1'b1;
      acc_code <= cur_code;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .frame_valid  (frame_valid),
    .frame_hit    (frame_hit),
    .frame_code   (frame_code),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed),
    .key_released (key_released),
    .state        (dbg_state)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle
// frames). A keypad model pulls column lines low for every pressed key
// whose row is strobed. Each vector holds a key set for a whole number of
// frames, starting right after a frame-end edge, then checks the held
// outputs, the pulse counts and the cycle the pulse appeared.
module tb_keypad_scan;
  import keypad_scan_pkg::*;

  localparam int FRAME = 16;

  logic             clk;
  logic             rst;
  logic [3:0]       row;
  logic [3:0]       col;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_pressed;
  logic             key_released;
  deb_state_t       dbg_state;

  logic [15:0] keys;       // bit {r,c} set = key at row r, col c pressed
  int          cyc;        // clock edges since reset release
  int          checks;
  int          errors;

  logic [3:0] exp_row [4];

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic        exp_valid;
    logic [3:0]  exp_code;
    int          exp_press;
    int          exp_rel;
    int          exp_cyc;    // cycle of the pulse within the vector, 0 = none
  } vec_t;

  vec_t vecs [14];

  keypad_scan #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .row          (row),
    .col          (col),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_pressed  (key_pressed),
    .key_released (key_released),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model: a pressed key connects its row line to its column.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !row[r]) col[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Driver: hold a key set for v.frames frames, sampling #1 after each edge.
  task automatic apply_vec(input vec_t v, input string tag);
    int np, nr, pc, row_err, ovl;
    np = 0; nr = 0; pc = 0; row_err = 0; ovl = 0;
    keys = v.keys;
    for (int j = 1; j <= FRAME * v.frames; j++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (row !== exp_row[(cyc >> 2) & 3]) row_err++;
      if (key_pressed === 1'b1) begin np++; pc = j; end
      if (key_released === 1'b1) begin nr++; pc = j; end
      if (key_pressed === 1'b1 && key_released === 1'b1) ovl++;
    end
    check({tag, " key_valid"}, int'(key_valid), int'(v.exp_valid));
    check({tag, " key_code"}, int'(key_code), int'(v.exp_code));
    check({tag, " pressed_cycles"}, np, v.exp_press);
    check({tag, " released_cycles"}, nr, v.exp_rel);
    check({tag, " row_errors"}, row_err, 0);
    check({tag, " pulse_overlap"}, ovl, 0);
    if (v.exp_cyc != 0) check({tag, " pulse_cycle"}, pc, v.exp_cyc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    keys   = 16'h0000;
    exp_row[0] = 4'b1110;
    exp_row[1] = 4'b1101;
    exp_row[2] = 4'b1011;
    exp_row[3] = 4'b0111;

    // idle, press/release of 0x9, bounce, two-key priority, release bounce
    vecs[0]  = '{16'h0000, 6, 1'b0, 4'h0, 0, 0, 0};
    vecs[1]  = '{16'h0200, 6, 1'b1, 4'h9, 1, 0, 48};
    vecs[2]  = '{16'h0000, 3, 1'b0, 4'h9, 0, 1, 48};
    vecs[3]  = '{16'h0200, 2, 1'b0, 4'h9, 0, 0, 0};
    vecs[4]  = '{16'h0000, 1, 1'b0, 4'h9, 0, 0, 0};
    vecs[5]  = '{16'h0200, 2, 1'b0, 4'h9, 0, 0, 0};
    vecs[6]  = '{16'h0200, 1, 1'b1, 4'h9, 1, 0, 16};
    vecs[7]  = '{16'h0000, 3, 1'b0, 4'h9, 0, 1, 48};
    vecs[8]  = '{16'h2004, 3, 1'b1, 4'h2, 1, 0, 48};
    vecs[9]  = '{16'h2000, 3, 1'b0, 4'h2, 0, 1, 48};
    vecs[10] = '{16'h2000, 3, 1'b1, 4'hD, 1, 0, 48};
    vecs[11] = '{16'h0000, 2, 1'b1, 4'hD, 0, 0, 0};
    vecs[12] = '{16'h2000, 1, 1'b1, 4'hD, 0, 0, 0};
    vecs[13] = '{16'h0000, 3, 1'b0, 4'hD, 0, 1, 48};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset row", int'(row), 4'b1110);
    check("reset key_valid", int'(key_valid), 0);
    check("reset key_code", int'(key_code), 0);
    check("reset pulses", int'({key_pressed, key_released}), 0);
    rst = 1'b0;
    cyc = 0;

    for (int i = 0; i < 14; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a press debounce (two matching frames seen).
    apply_vec('{16'h0200, 2, 1'b0, 4'hD, 0, 0, 0}, "pre_rst");
    check("pre_rst state", int'(dbg_state), int'(DEB_PRESS));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async row", int'(row), 4'b1110);
    check("rst_async key_code", int'(key_code), 0);
    check("rst_async key_valid", int'(key_valid), 0);
    check("rst_async pulses", int'({key_pressed, key_released}), 0);
    check("rst_async state", int'(dbg_state), int'(IDLE));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    // Key still held: progress was lost, so three fresh frames are needed.
    apply_vec('{16'h0200, 2, 1'b0, 4'h0, 0, 0, 0}, "post_rst_a");
    apply_vec('{16'h0200, 1, 1'b1, 4'h9, 1, 0, 16}, "post_rst_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
